// File: rtl/framer_pkg.sv
// ---------------------------------------------------------------------------
// framer_pkg -- shared types and constants for the result framer.
//   SYNC_BYTE_DEFAULT : default first byte of every frame
//   HDR_BYTES         : header length in bytes (series_id + length)
//   state_t           : framer FSM states
//   record_t          : one buffered result, {ema, sma}
// ---------------------------------------------------------------------------
package framer_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned HDR_BYTES         = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        SEQ      = 3'd2,
        HDR      = 3'd3,
        WAIT_REC = 3'd4,
        REC      = 3'd5,
        CSUM     = 3'd6
    } state_t;

    // Low half is SMA so that byte 0..3 of the record is the wire order.
    typedef struct packed {
        logic [15:0] ema;
        logic [15:0] sma;
    } record_t;

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo -- synchronous record FIFO with a registered read port.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write request and record; ignored when full
//   pop, rdata   : read request; rdata updates on the edge that pops
//   level        : records currently stored
//   full, empty  : status decoded from the registered level
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module result_fifo
    import framer_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [31:0]   rdata_r;
    logic          wr_en_s;
    logic          rd_en_s;

    assign full    = (level_r == LW'(DEPTH));
    assign empty   = (level_r == {LW{1'b0}});
    assign wr_en_s = push & ~full;
    assign rd_en_s = pop & ~empty;
    assign level   = level_r;
    assign rdata   = rdata_r;

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and the registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            rdata_r  <= 32'h0000_0000;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                rdata_r  <= mem_r[rd_ptr_r];
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/result_framer.sv
// ---------------------------------------------------------------------------
// result_framer -- buffers SMA/EMA results and sends one checksummed frame
// per series over a byte-wide UART transmit interface.
//   clk, reset_n            : clock, asynchronous active-low reset
//   frame_start             : opens a frame (honoured only when idle)
//   series_id_in, length_in : header fields latched on frame_start
//   res_valid, sma_in, ema_in : result strobe and values
//   tx_ready                : transmitter can take a byte
//   tx_send, tx_data        : one-cycle byte strobe and the byte
//   busy                    : a frame is in progress
//   overflow                : sticky, a result was dropped on a full FIFO
//   fifo_level              : buffered records
// Frame: SYNC, [SEQ], id[4], length[4], length x {sma, ema}, CSUM (LE).
// Optional macro FRAMER_SEQ_EN adds an 8-bit frame sequence byte after SYNC.
// ---------------------------------------------------------------------------
module result_framer
    import framer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       frame_start,
    input  logic [31:0]                series_id_in,
    input  logic [31:0]                length_in,
    input  logic                       res_valid,
    input  logic [15:0]                sma_in,
    input  logic [15:0]                ema_in,
    input  logic                       tx_ready,
    output logic                       tx_send,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam logic [2:0] HDR_LAST = 3'(HDR_BYTES - 1);

    state_t      state_r;
    logic [31:0] id_r;
    logic [31:0] len_r;
    logic [31:0] rec_cnt_r;
    logic [2:0]  hdr_idx_r;
    logic [1:0]  rec_idx_r;
    logic [7:0]  csum_r;
    logic        tx_send_r;
    logic [7:0]  tx_data_r;
    logic        busy_r;
    logic        overflow_r;
`ifdef FRAMER_SEQ_EN
    logic [7:0]  seq_r;
`endif

    record_t     wr_rec_s;
    record_t     rd_rec_s;
    logic [31:0] rd_word_s;
    logic [63:0] hdr_word_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        pop_s;
    logic        send_ok_s;
    logic        start_ok_s;
    logic [7:0]  byte_s;

    assign wr_rec_s   = '{ema: ema_in, sma: sma_in};
    assign rd_rec_s   = record_t'(rd_word_s);
    assign hdr_word_s = {len_r, id_r};
    // The cycle after a send is a guard cycle, hence the tx_send_r term.
    assign send_ok_s  = tx_ready & ~tx_send_r;
    assign start_ok_s = frame_start & (state_r == IDLE);
    // The head record is popped once per WAIT_REC visit; it stays in rdata during REC.
    assign pop_s      = (state_r == WAIT_REC) & ~fifo_empty_s;

    assign tx_send    = tx_send_r;
    assign tx_data    = tx_data_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (res_valid),
        .pop     (pop_s),
        .wdata   (wr_rec_s),
        .rdata   (rd_word_s),
        .level   (fifo_level),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Byte offered in the current state.
    always_comb begin
        byte_s = 8'h00;
        case (state_r)
            SYNC:    byte_s = SYNC_BYTE;
`ifdef FRAMER_SEQ_EN
            SEQ:     byte_s = seq_r;
`endif
            HDR:     byte_s = hdr_word_s[{hdr_idx_r, 3'b000} +: 8];
            REC:     byte_s = rd_rec_s[{rec_idx_r, 3'b000} +: 8];
            CSUM:    byte_s = csum_r;
            default: byte_s = 8'h00;
        endcase
    end

    // Framing FSM with registered outputs and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            id_r       <= 32'h0000_0000;
            len_r      <= 32'h0000_0000;
            rec_cnt_r  <= 32'h0000_0000;
            hdr_idx_r  <= 3'd0;
            rec_idx_r  <= 2'd0;
            csum_r     <= 8'h00;
            tx_send_r  <= 1'b0;
            tx_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
`ifdef FRAMER_SEQ_EN
            seq_r      <= 8'h00;
`endif
        end else begin
            tx_send_r  <= 1'b0;
            // A drop in the same cycle as the clearing start is still recorded.
            overflow_r <= (overflow_r & ~start_ok_s) | (res_valid & fifo_full_s);
            case (state_r)
                IDLE: begin
                    if (frame_start) begin
                        id_r      <= series_id_in;
                        len_r     <= length_in;
                        csum_r    <= 8'h00;
                        rec_cnt_r <= 32'h0000_0000;
                        hdr_idx_r <= 3'd0;
                        rec_idx_r <= 2'd0;
                        busy_r    <= 1'b1;
                        state_r   <= SYNC;
                    end
                end
                SYNC: begin
                    if (send_ok_s) begin
                        tx_send_r <= 1'b1;
                        tx_data_r <= byte_s;
`ifdef FRAMER_SEQ_EN
                        state_r   <= SEQ;
`else
                        state_r   <= HDR;
`endif
                    end
                end
`ifdef FRAMER_SEQ_EN
                SEQ: begin
                    if (send_ok_s) begin
                        tx_send_r <= 1'b1;
                        tx_data_r <= byte_s;
                        csum_r    <= csum_r ^ byte_s;
                        state_r   <= HDR;
                    end
                end
`endif
                HDR: begin
                    if (send_ok_s) begin
                        tx_send_r <= 1'b1;
                        tx_data_r <= byte_s;
                        csum_r    <= csum_r ^ byte_s;
                        hdr_idx_r <= hdr_idx_r + 3'd1;
                        if (hdr_idx_r == HDR_LAST) begin
                            state_r <= (len_r != 32'h0000_0000) ? WAIT_REC : CSUM;
                        end
                    end
                end
                WAIT_REC: begin
                    if (!fifo_empty_s) begin
                        rec_idx_r <= 2'd0;
                        state_r   <= REC;
                    end
                end
                REC: begin
                    if (send_ok_s) begin
                        tx_send_r <= 1'b1;
                        tx_data_r <= byte_s;
                        csum_r    <= csum_r ^ byte_s;
                        rec_idx_r <= rec_idx_r + 2'd1;
                        if (rec_idx_r == 2'd3) begin
                            rec_cnt_r <= rec_cnt_r + 32'd1;
                            state_r   <= ((rec_cnt_r + 32'd1) == len_r) ? CSUM : WAIT_REC;
                        end
                    end
                end
                CSUM: begin
                    if (send_ok_s) begin
                        tx_send_r <= 1'b1;
                        tx_data_r <= byte_s;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
`ifdef FRAMER_SEQ_EN
                        seq_r     <= seq_r + 8'd1;
`endif
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_framer.sv
// ---------------------------------------------------------------------------
// tb_result_framer -- directed bench for result_framer (DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are captured on
// the falling edge. Expected frames are built from hand-computed checksums.
// ---------------------------------------------------------------------------
module tb_result_framer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_start;
    logic [31:0] series_id_in;
    logic [31:0] length_in;
    logic        res_valid;
    logic [15:0] sma_in;
    logic [15:0] ema_in;
    logic        tx_ready;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_level;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          b2b_err    = 0;
    int          ready_err  = 0;
    logic        last_send  = 1'b0;
    logic        last_ready = 1'b0;
    logic [7:0]  seq_exp    = 8'h00;
    logic [7:0]  rx_q[$];
    logic [31:0] exp_recs[$];
    int          snap;

`ifdef FRAMER_SEQ_EN
    localparam int SEQ_B = 1;
`else
    localparam int SEQ_B = 0;
`endif

    result_framer #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .series_id_in (series_id_in),
        .length_in    (length_in),
        .res_valid    (res_valid),
        .sma_in       (sma_in),
        .ema_in       (ema_in),
        .tx_ready     (tx_ready),
        .tx_send      (tx_send),
        .tx_data      (tx_data),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Byte capture and handshake monitor.
    always @(negedge clk) begin
        if (tx_send) begin
            rx_q.push_back(tx_data);
            if (last_send) b2b_err++;
            if (!last_ready) ready_err++;
        end
        last_send  = tx_send;
        last_ready = tx_ready;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] id, input logic [31:0] len);
        series_id_in = id;
        length_in    = len;
        frame_start  = 1'b1;
        tick();
        frame_start  = 1'b0;
    endtask

    task automatic push_rec(input logic [15:0] sma, input logic [15:0] ema);
        sma_in    = sma;
        ema_in    = ema;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, busy, 32'd0);
        @(negedge clk);
        tick();
    endtask

    // Build the expected frame from header fields, exp_recs and a hand checksum.
    task automatic expect_frame(input string tag, input logic [31:0] id,
                                input logic [31:0] len, input logic [7:0] csum);
        logic [7:0] exp_q[$];
        logic [7:0] c = csum;
        exp_q.push_back(8'hA5);
`ifdef FRAMER_SEQ_EN
        exp_q.push_back(seq_exp);
        c = c ^ seq_exp;
        seq_exp = seq_exp + 8'd1;
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back(id[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_q.push_back(len[8*i +: 8]);
        foreach (exp_recs[k]) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(exp_recs[k][8*i +: 8]);
        end
        exp_q.push_back(c);
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_recs.delete();
    endtask

    initial begin
        reset_n      = 1'b0;
        frame_start  = 1'b0;
        series_id_in = 32'd0;
        length_in    = 32'd0;
        res_valid    = 1'b0;
        sma_in       = 16'd0;
        ema_in       = 16'd0;
        tx_ready     = 1'b1;
        repeat (3) tick();
        check("rst_tx_send", tx_send, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        check("rst_level", fifo_level, 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single record frame
        start(32'h0000_0007, 32'd1);
        check("t1_busy", busy, 32'd1);
        push_rec(16'h1234, 16'h5678);
        exp_recs.push_back(32'h5678_1234);
        wait_idle("t1");
        expect_frame("t1", 32'h0000_0007, 32'd1, 8'h0E);
        check("t1_busy_end", busy, 32'd0);

        // Zero-length frame leaves the buffered record alone
        push_rec(16'hAAAA, 16'hBBBB);
        start(32'h0000_0003, 32'd0);
        wait_idle("t2");
        expect_frame("t2", 32'h0000_0003, 32'd0, 8'h03);
        check("t2_level", fifo_level, 32'd1);
        start(32'h0000_0001, 32'd1);
        exp_recs.push_back(32'hBBBB_AAAA);
        wait_idle("t2d");
        expect_frame("t2d", 32'h0000_0001, 32'd1, 8'h00);
        check("t2d_level", fifo_level, 32'd0);

        // Overflow on the fifth push, cleared by the next start
        push_rec(16'h0011, 16'h0022);
        push_rec(16'h0033, 16'h0044);
        push_rec(16'h0055, 16'h0066);
        push_rec(16'h0077, 16'h0088);
        check("t3_ovf_pre", overflow, 32'd0);
        push_rec(16'h0099, 16'h00AA);
        check("t3_level", fifo_level, 32'd4);
        check("t3_ovf", overflow, 32'd1);
        start(32'h0000_0010, 32'd4);
        check("t3_ovf_clr", overflow, 32'd0);
        exp_recs.push_back(32'h0022_0011);
        exp_recs.push_back(32'h0044_0033);
        exp_recs.push_back(32'h0066_0055);
        exp_recs.push_back(32'h0088_0077);
        wait_idle("t3");
        expect_frame("t3", 32'h0000_0010, 32'd4, 8'h9C);
        check("t3_level_end", fifo_level, 32'd0);

        // Backpressure in the middle of the header
        start(32'hDEAD_BEEF, 32'd0);
        repeat (5) tick();
        tx_ready = 1'b0;
        tick();
        snap = rx_q.size();
        repeat (19) tick();
        check("t4_stall_bytes", rx_q.size(), snap);
        check("t4_stall_busy", busy, 32'd1);
        tx_ready = 1'b1;
        wait_idle("t4");
        expect_frame("t4", 32'hDEAD_BEEF, 32'd0, 8'h22);

        // Starvation in WAIT_REC with an ignored second start
        push_rec(16'h0102, 16'h0304);
        start(32'h0000_0020, 32'd2);
        repeat (30) tick();
        check("t5_wait_busy", busy, 32'd1);
        check("t5_wait_bytes", rx_q.size(), 32'(13 + SEQ_B));
        start(32'h0000_0099, 32'd5);
        push_rec(16'h0506, 16'h0708);
        exp_recs.push_back(32'h0304_0102);
        exp_recs.push_back(32'h0708_0506);
        wait_idle("t5");
        expect_frame("t5", 32'h0000_0020, 32'd2, 8'h2A);
        check("t5_level", fifo_level, 32'd0);
        repeat (20) tick();
        check("t5_no_extra", rx_q.size(), 32'd0);

        // Reset in the middle of a frame stops output at once
        start(32'h0000_0055, 32'd0);
        repeat (6) tick();
        reset_n = 1'b0;
        #1;
        check("t6_send", tx_send, 32'd0);
        check("t6_busy", busy, 32'd0);
        tick();
        reset_n = 1'b1;
        rx_q.delete();
        seq_exp = 8'h00;
        repeat (20) tick();
        check("t6_silent", rx_q.size(), 32'd0);

`ifdef FRAMER_SEQ_EN
        // Three back-to-back zero-length frames carry SEQ 00, 01, 02
        for (int f = 0; f < 3; f++) begin
            start(32'h0000_0000, 32'd0);
            wait_idle("t7");
            expect_frame($sformatf("t7_f%0d", f), 32'h0000_0000, 32'd0, 8'h00);
        end
`endif

        check("guard_cycles", b2b_err, 32'd0);
        check("ready_honoured", ready_err, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
